conv_weights_load_scheduler: RTL and testbench
==============================================

CONV_WEIGHTS_LOAD_SCHEDULER -- requirements
Module: conv_weights_load_scheduler

Interface
REQ-001 SHALL have parameter WORD_W, default 512, meaning weight word width in bits.
REQ-002 SHALL have parameter ADR_W, default 16, meaning weight buffer address width.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset, input, 1, reset: synchronous, active-high, sampled on clk.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a layer.
REQ-006 SHALL have port num_tiles, input, 16, number of weight tiles in the layer; latched on start.
REQ-007 SHALL have port tile_words, input, ADR_W, words per tile; latched on start.
REQ-008 SHALL have port ddr_valid, input, 1, DDR weight word valid.
REQ-009 SHALL have port ddr_ready, output, 1, scheduler accepts a DDR word.
REQ-010 SHALL have port ddr_data, input, WORD_W, DDR weight word.
REQ-011 SHALL have port wt_en, output, 1, write strobe to the ping-pong write side.
REQ-012 SHALL have port wt_adr, output, ADR_W, write address.
REQ-013 SHALL have port wt_data, output, WORD_W, write data.
REQ-014 SHALL have port swap, output, 1, one-cycle pulse that flips the ping-pong buffers.
REQ-015 SHALL have port compute_start, output, 1, one-cycle pulse telling compute that a new tile is readable.
REQ-016 SHALL have port compute_done, input, 1, one-cycle pulse: compute finished reading the current tile.
REQ-017 SHALL have port busy, output, 1, high from the cycle after an accepted start until the done pulse.
REQ-018 SHALL have port done, output, 1, one-cycle pulse when the layer is complete.

Function
REQ-019 SHALL implement states IDLE, FILL, WAIT_SWAP, SWAP, DRAIN and FIN.
- IDLE -> FILL on start when num_tiles != 0 and tile_words != 0.
- IDLE -> FIN on start when either value is 0.
REQ-020 SHALL set ddr_ready = 1 only in FILL; wt_en = ddr_valid & ddr_ready; wt_data = ddr_data combinationally.
REQ-021 SHALL set wt_adr to the word counter, which starts at 0 for each tile and increments by 1 on each wt_en.
REQ-022 SHALL leave FILL for WAIT_SWAP in the cycle after the write at wt_adr = tile_words-1, and clear the word counter to 0.
REQ-023 SHALL track compute_busy:
- set in the cycle compute_start is asserted;
- cleared on compute_done.
REQ-024 SHALL go from WAIT_SWAP to SWAP when compute_busy = 0, or when compute_done is asserted in that same cycle.
REQ-025 SHALL hold swap = 1 for exactly the one cycle spent in SWAP, and assert compute_start in the following cycle.
REQ-026 SHALL count filled tiles. After SWAP:
- go to FILL if tiles_filled < num_tiles, so the next tile loads while compute runs;
- otherwise go to DRAIN.
REQ-027 SHALL go from DRAIN to FIN on compute_done; FIN asserts done for one cycle and then returns to IDLE.
REQ-028 SHALL ignore start whenever the state is not IDLE.
REQ-029 SHALL treat a compute_done that arrives while compute_busy = 0 as a no-op.
REQ-030 SHALL wrap no counter: num_tiles up to 65535 and tile_words up to 2^ADR_W-1 are supported exactly.
REQ-031 SHALL hold wt_adr stable and keep the word counter unchanged while ddr_valid = 0 in FILL (back-pressure from DDR).

Reset
REQ-032 SHALL on reset (including mid-layer) force:
- state IDLE;
- all counters 0 and compute_busy 0;
- ddr_ready, wt_en, swap, compute_start, busy and done all 0 in the following cycle.
REQ-033 SHALL ignore compute_done and ddr_valid while reset is high.

Verification
REQ-034 num_tiles=1, tile_words=4, ddr_valid=1 continuous:
- wt_adr 0,1,2,3 on 4 consecutive cycles;
- swap 2 cycles after the last write, compute_start 1 cycle after swap;
- compute_done -> done the next cycle.
REQ-035 num_tiles=3, tile_words=2, compute_done held off 20 cycles:
- tile 1 fills, then the block sits in WAIT_SWAP with ddr_ready=0;
- the second swap follows compute_done by 1 cycle;
- exactly 3 swap and 3 compute_start pulses are seen in total.
REQ-036 compute_done in the same cycle as WAIT_SWAP entry -> swap next cycle, no extra stall.
REQ-037 num_tiles=0 or tile_words=0 on start -> done 1 cycle later, no wt_en, no swap.
REQ-038 ddr_valid toggled 1,0,1,0 -> wt_adr advances only on valid cycles; the address sequence has no gaps.
REQ-039 reset asserted mid-FILL at wt_adr=5 -> all outputs 0 the next cycle; a new start refills from wt_adr=0.

Source files
------------

// File: rtl/conv_weights_load_scheduler_if.sv
// Bundle of the handshake and data signals between the weight-load scheduler
// and its surroundings (layer control, DDR stream, ping-pong buffer, compute).
interface conv_weights_load_scheduler_if #(
    parameter int WORD_W = 512,
    parameter int ADR_W  = 16
);
    logic              start;
    logic [15:0]       num_tiles;
    logic [ADR_W-1:0]  tile_words;
    logic              ddr_valid;
    logic              ddr_ready;
    logic [WORD_W-1:0] ddr_data;
    logic              wt_en;
    logic [ADR_W-1:0]  wt_adr;
    logic [WORD_W-1:0] wt_data;
    logic              swap;
    logic              compute_start;
    logic              compute_done;
    logic              busy;
    logic              done;

    // Environment side: drives layer control, DDR stream and compute feedback.
    modport master (
        output start, num_tiles, tile_words, ddr_valid, ddr_data, compute_done,
        input  ddr_ready, wt_en, wt_adr, wt_data, swap, compute_start, busy, done
    );

    // Scheduler side.
    modport slave (
        input  start, num_tiles, tile_words, ddr_valid, ddr_data, compute_done,
        output ddr_ready, wt_en, wt_adr, wt_data, swap, compute_start, busy, done
    );
endinterface

// File: rtl/conv_weights_load_scheduler.sv
// Convolution weight load scheduler: streams weight tiles from DDR into the
// write side of a ping-pong buffer, swaps buffers once compute has released
// the read side, and overlaps the next tile load with compute.
module conv_weights_load_scheduler #(
    parameter int WORD_W = 512,
    parameter int ADR_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    conv_weights_load_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_SWAP = 3'd2,
        ST_SWAP      = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_FIN       = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADR_W-1:0] tile_words_q, tile_words_d;
    logic [15:0]      num_tiles_q, num_tiles_d;
    logic [15:0]      tiles_filled_q, tiles_filled_d;
    logic             compute_busy_q, compute_busy_d;
    logic             compute_start_q, compute_start_d;
    logic             swap_q, swap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             wr_s;
    logic             last_wr_s;
    logic             cbusy_eff_s;
    logic             cdone_s;

    // DDR words are only taken while filling; reset blocks any write in its own cycle.
    assign bus.ddr_ready     = (state_q == ST_FILL) & ~reset;
    assign wr_s              = bus.ddr_valid & bus.ddr_ready;
    assign bus.wt_en         = wr_s;
    assign bus.wt_adr        = word_cnt_q;
    assign bus.wt_data       = bus.ddr_data;
    assign bus.swap          = swap_q;
    assign bus.compute_start = compute_start_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

    // Final word of a tile; tile_words_q is never 0 while in FILL.
    assign last_wr_s   = wr_s & (word_cnt_q == (tile_words_q - {{(ADR_W-1){1'b0}}, 1'b1}));
    // Compute counts as busy from the compute_start cycle onward.
    assign cbusy_eff_s = compute_busy_q | compute_start_q;
    // compute_done only matters while compute actually holds a tile.
    assign cdone_s     = bus.compute_done & cbusy_eff_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        tile_words_d    = tile_words_q;
        num_tiles_d     = num_tiles_q;
        tiles_filled_d  = tiles_filled_q;
        compute_busy_d  = cbusy_eff_s & ~bus.compute_done;
        compute_start_d = (state_q == ST_SWAP);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    num_tiles_d    = bus.num_tiles;
                    tile_words_d   = bus.tile_words;
                    word_cnt_d     = {ADR_W{1'b0}};
                    tiles_filled_d = 16'd0;
                    if ((bus.num_tiles != 16'd0) && (bus.tile_words != {ADR_W{1'b0}})) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (last_wr_s) begin
                    word_cnt_d     = {ADR_W{1'b0}};
                    tiles_filled_d = tiles_filled_q + 16'd1;
                    state_d        = ST_WAIT_SWAP;
                end else if (wr_s) begin
                    word_cnt_d = word_cnt_q + {{(ADR_W-1){1'b0}}, 1'b1};
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            ST_WAIT_SWAP: begin
                if (!cbusy_eff_s || bus.compute_done) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_WAIT_SWAP;
                end
            end
            ST_SWAP: begin
                // Overlap the next tile load with compute of the one just swapped in.
                if (tiles_filled_q < num_tiles_q) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cdone_s) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        swap_d = (state_d == ST_SWAP);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            word_cnt_q      <= {ADR_W{1'b0}};
            tile_words_q    <= {ADR_W{1'b0}};
            num_tiles_q     <= 16'd0;
            tiles_filled_q  <= 16'd0;
            compute_busy_q  <= 1'b0;
            compute_start_q <= 1'b0;
            swap_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            tile_words_q    <= tile_words_d;
            num_tiles_q     <= num_tiles_d;
            tiles_filled_q  <= tiles_filled_d;
            compute_busy_q  <= compute_busy_d;
            compute_start_q <= compute_start_d;
            swap_q          <= swap_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_weights_load_scheduler.sv
// Bench for conv_weights_load_scheduler: a table of whole layers checked
// against hand-computed counts, a scoreboard of expected (address, data)
// writes, and hand-written cycle-exact sequences for the timing corners.
module tb_conv_weights_load_scheduler;

    localparam int WW = 32;
    localparam int AW = 4;

    logic clk;
    logic reset;

    conv_weights_load_scheduler_if #(.WORD_W(WW), .ADR_W(AW)) intf ();

    conv_weights_load_scheduler #(.WORD_W(WW), .ADR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] adr;
        logic [WW-1:0] data;
    } exp_t;

    typedef struct {
        int nt;
        int tw;
        bit toggle;
        int lat;
        int exp_swaps;
        int exp_starts;
        int exp_writes;
        int done_lat;
    } row_t;

    exp_t exp_q[$];
    row_t rows[6];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int layer_id = 0;
    int src_idx = 0;
    int src_total = 0;
    int n_wr = 0;
    int n_swap = 0;
    int n_cs = 0;
    int n_done = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int cfg_lat = -1;
    bit cfg_toggle = 1'b0;
    bit comp_pending = 1'b0;
    int comp_cnt = 0;
    bit phase = 1'b0;

    logic        drv_start = 1'b0;
    logic        drv_reset = 1'b1;
    logic        drv_cdone = 1'b0;
    logic [15:0] drv_nt = 16'd0;
    logic [AW-1:0] drv_tw = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WW-1:0] word_of(input int k);
        return {8'hA5, 8'(layer_id), 16'(k)};
    endfunction

    // New layer: expected writes are queued up front, DDR source rewinds.
    task automatic push_exp(input int nt, input int tw);
        exp_t e;
        exp_q.delete();
        layer_id++;
        src_idx = 0;
        src_total = (nt == 0 || tw == 0) ? 0 : nt * tw;
        for (int k = 0; k < src_total; k++) begin
            e.adr  = AW'(k % tw);
            e.data = word_of(k);
            exp_q.push_back(e);
        end
        n_wr = 0; n_swap = 0; n_cs = 0; n_done = 0;
    endtask

    // One clock: drive inputs after the edge, sample and score at the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        reset = drv_reset;
        intf.start = drv_start;
        drv_start = 1'b0;
        intf.num_tiles = drv_nt;
        intf.tile_words = drv_tw;
        phase = ~phase;
        if (src_idx < src_total && (!cfg_toggle || phase)) begin
            intf.ddr_valid = 1'b1;
            intf.ddr_data  = word_of(src_idx);
        end else begin
            intf.ddr_valid = 1'b0;
            intf.ddr_data  = WW'($urandom);
        end
        intf.compute_done = drv_cdone;
        drv_cdone = 1'b0;
        if (cfg_lat >= 0 && comp_pending) begin
            if (comp_cnt <= 0) begin
                intf.compute_done = 1'b1;
                comp_pending = 1'b0;
            end else begin
                comp_cnt--;
            end
        end
        @(negedge clk);
        cyc++;
        if (intf.wt_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("wt_unexpected", 64'(intf.wt_adr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wt_adr", 64'(intf.wt_adr), 64'(e.adr));
                chk("wt_data", 64'(intf.wt_data), 64'(e.data));
            end
            src_idx++;
        end
        if (intf.swap) n_swap++;
        if (intf.compute_start) begin
            n_cs++;
            comp_pending = 1'b1;
            comp_cnt = cfg_lat;
        end
        if (intf.done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_layer(input int nt, input int tw);
        push_exp(nt, tw);
        drv_nt = 16'(nt);
        drv_tw = AW'(tw);
        drv_start = 1'b1;
        tick();
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string nm);
        int g = 0;
        while (n_done == 0 && g < 3000) begin
            tick();
            g++;
        end
        chk({nm, "_done_seen"}, 64'(n_done), 64'd1);
    endtask

    task automatic run_row(input int r);
        cfg_toggle = rows[r].toggle;
        cfg_lat = rows[r].lat;
        comp_pending = 1'b0;
        start_layer(rows[r].nt, rows[r].tw);
        tick();
        chk("row_busy_after_start", 64'(intf.busy), 64'd1);
        wait_done("row");
        if (rows[r].done_lat != 0) chk("row_done_latency", 64'(done_cyc - start_cyc), 64'(rows[r].done_lat));
        tick();
        chk("row_done_one_cycle", 64'(intf.done), 64'd0);
        chk("row_busy_after_done", 64'(intf.busy), 64'd0);
        chk("row_swaps", 64'(n_swap), 64'(rows[r].exp_swaps));
        chk("row_compute_starts", 64'(n_cs), 64'(rows[r].exp_starts));
        chk("row_writes", 64'(n_wr), 64'(rows[r].exp_writes));
        chk("row_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        cfg_toggle = 1'b0;
    endtask

    initial begin
        //          nt  tw  tog  lat swaps starts writes done_lat
        rows[0] = '{1,  4,  1'b0, 0, 1, 1, 4,  0};
        rows[1] = '{3,  2,  1'b0, 3, 3, 3, 6,  0};
        rows[2] = '{0,  4,  1'b0, 0, 0, 0, 0,  1};
        rows[3] = '{2,  0,  1'b0, 0, 0, 0, 0,  1};
        rows[4] = '{2,  5,  1'b1, 2, 2, 2, 10, 0};
        rows[5] = '{2,  15, 1'b0, 30, 2, 2, 30, 0};

        reset = 1'b1;
        intf.start = 1'b0; intf.num_tiles = 16'd0; intf.tile_words = '0;
        intf.ddr_valid = 1'b0; intf.ddr_data = '0; intf.compute_done = 1'b0;

        // Reset state.
        drv_reset = 1'b1;
        repeat (3) tick();
        drv_reset = 1'b0;
        tick();
        chk("rst_ddr_ready", 64'(intf.ddr_ready), 64'd0);
        chk("rst_wt_en", 64'(intf.wt_en), 64'd0);
        chk("rst_swap", 64'(intf.swap), 64'd0);
        chk("rst_compute_start", 64'(intf.compute_start), 64'd0);
        chk("rst_busy", 64'(intf.busy), 64'd0);
        chk("rst_done", 64'(intf.done), 64'd0);

        // Single tile, cycle-exact; a second start during FILL is ignored.
        cfg_lat = -1;
        start_layer(1, 4);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                drv_start = 1'b1;
                drv_nt = 16'd5;
            end
            tick();
            chk("a_wt_en", 64'(intf.wt_en), 64'd1);
            chk("a_wt_adr", 64'(intf.wt_adr), 64'(i));
        end
        tick();
        chk("a_wait_ready", 64'(intf.ddr_ready), 64'd0);
        chk("a_wait_swap", 64'(intf.swap), 64'd0);
        tick();
        chk("a_swap", 64'(intf.swap), 64'd1);
        tick();
        chk("a_cstart", 64'(intf.compute_start), 64'd1);
        chk("a_swap_one_cycle", 64'(intf.swap), 64'd0);
        drv_cdone = 1'b1;
        tick();
        chk("a_no_done_yet", 64'(intf.done), 64'd0);
        tick();
        chk("a_done", 64'(intf.done), 64'd1);
        tick();
        chk("a_done_pulse", 64'(intf.done), 64'd0);
        chk("a_idle_busy", 64'(intf.busy), 64'd0);
        chk("a_swap_count", 64'(n_swap), 64'd1);
        chk("a_write_count", 64'(n_wr), 64'd4);

        // Table of whole layers.
        for (int r = 0; r < 6; r++) run_row(r);

        // compute_done on the WAIT_SWAP entry cycle: swap follows with no stall.
        cfg_lat = -1;
        start_layer(2, 2);
        repeat (6) tick();
        drv_cdone = 1'b1;
        tick();
        chk("b_entry_ready", 64'(intf.ddr_ready), 64'd0);
        chk("b_entry_swap", 64'(intf.swap), 64'd0);
        tick();
        chk("b_swap_no_stall", 64'(intf.swap), 64'd1);
        comp_pending = 1'b0;
        cfg_lat = 0;
        wait_done("b");
        chk("b_swap_count", 64'(n_swap), 64'd2);

        // Compute held off: block parks in WAIT_SWAP until compute_done.
        cfg_lat = -1;
        begin
            int bad = 0;
            start_layer(3, 2);
            repeat (6) tick();
            for (int i = 0; i < 20; i++) begin
                tick();
                if (intf.ddr_ready || intf.swap || intf.wt_en) bad++;
            end
            chk("c_stall", 64'(bad), 64'd0);
        end
        drv_cdone = 1'b1;
        tick();
        chk("c_swap_wait", 64'(intf.swap), 64'd0);
        tick();
        chk("c_swap_after_done", 64'(intf.swap), 64'd1);
        comp_pending = 1'b0;
        cfg_lat = 0;
        wait_done("c");
        chk("c_swap_count", 64'(n_swap), 64'd3);
        chk("c_cstart_count", 64'(n_cs), 64'd3);
        chk("c_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of FILL, then a clean refill from address 0.
        cfg_lat = -1;
        start_layer(1, 12);
        repeat (5) tick();
        drv_reset = 1'b1;
        tick();
        chk("d_adr_at_reset", 64'(intf.wt_adr), 64'd5);
        drv_reset = 1'b0;
        tick();
        chk("d_rst_ready", 64'(intf.ddr_ready), 64'd0);
        chk("d_rst_wt_en", 64'(intf.wt_en), 64'd0);
        chk("d_rst_wt_adr", 64'(intf.wt_adr), 64'd0);
        chk("d_rst_swap", 64'(intf.swap), 64'd0);
        chk("d_rst_cstart", 64'(intf.compute_start), 64'd0);
        chk("d_rst_busy", 64'(intf.busy), 64'd0);
        chk("d_rst_done", 64'(intf.done), 64'd0);
        cfg_lat = 0;
        comp_pending = 1'b0;
        start_layer(1, 3);
        tick();
        chk("d_refill_en", 64'(intf.wt_en), 64'd1);
        chk("d_refill_adr0", 64'(intf.wt_adr), 64'd0);
        wait_done("d");
        chk("d_write_count", 64'(n_wr), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
